psp_retire_monitor: RTL and testbench
=====================================

Name: psp_retire_monitor

Overview:
- Synthesizable retirement tracker for the PSP core; consumes up to NRET retirement reports per cycle.
- Assigns a monotonically increasing order number to each retired instruction.
- Checks PC continuity, retire-mask legality and a no-retire watchdog; merges an external error code; reports sticky PASS/FAIL.
- Sits beside the core's RVFI output; feeds the RVFI checker and the board LEDs/err display.

Parameters:
NRET, 2, retirement channels per cycle (1..4)
XLEN, 32, PC width
ORDER_W, 64, order counter width
WDT_W, 16, watchdog counter width
WDT_LIMIT, 1000, idle cycles before timeout (must fit in WDT_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rvfi_valid  in  NRET  per-channel retire strobe; channel 0 is oldest
rvfi_pc_rdata  in  NRET*XLEN  PC of retiring insn, channel i at [i*XLEN +: XLEN]
rvfi_pc_wdata  in  NRET*XLEN  next PC of retiring insn
done_in  in  1  program-complete request from core
errcode_in  in  16  external checker code, 0 = no error
ch_order  out  NRET*ORDER_W  combinational order of each channel this cycle
order_count  out  ORDER_W  instructions retired so far
state  out  2  0 IDLE, 1 RUN, 2 PASS, 3 FAIL
pass  out  1  state==PASS
fail  out  1  state==FAIL
err_code  out  16  first error captured
err_order  out  ORDER_W  order_count when error captured

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: state IDLE, order_count 0, err_code 0, err_order 0, watchdog 0, last_pc_valid 0. pass and fail are therefore 0.
- Reset asserted in any state, including mid-run, PASS or FAIL, returns to the reset values on the next edge.
- Mask legality: rvfi_valid must be contiguous from bit 0 (e.g. 01, 11 legal; 10 illegal) → error 0x0003.
- ch_order[i] = order_count + i for each valid channel; 0 for invalid channels. Purely combinational.
- order_count += popcount(rvfi_valid) each cycle in IDLE/RUN when no error fires that cycle. Wraps modulo 2^ORDER_W.
- PC chain, within a cycle: for i>0, valid channel i requires pc_rdata[i] == pc_wdata[i-1].
- PC chain, across cycles: channel 0 requires pc_rdata[0] == last_pc when last_pc_valid.
- last_pc is updated to pc_wdata of the highest valid channel; last_pc_valid is set to 1.
- Any PC mismatch → error 0x0001.
- Watchdog:
  - Counts cycles in IDLE/RUN with rvfi_valid==0; clears on any retire.
  - Reaching WDT_LIMIT → error 0x0002.
- Error priority in one cycle: errcode_in!=0 (code = errcode_in) > 0x0003 > 0x0001 > 0x0002.
- First error wins:
  - err_code and err_order are captured once; err_order = order_count before the failing cycle's increment.
  - order_count does not increment on the failing cycle.
- FSM:
  - IDLE → RUN on the first legal retire.
  - IDLE/RUN → FAIL on any error.
  - IDLE/RUN → PASS on done_in with no error that cycle (error and done together → FAIL).
  - PASS and FAIL are absorbing until reset; in them all inputs are ignored and counters freeze.
  - done_in in IDLE with no retire → PASS (empty program allowed).
- Latency: pass/fail/err_* visible the cycle after the triggering edge.

Optional Feature:
PSP_RETIRE_PCCHK_EN
- Defined: PC chain checking and error 0x0001 as above; last_pc register present.
- Undefined: PC inputs unused; no last_pc storage; code 0x0001 is never produced. All other behaviour is unchanged.

Test Plan:
- NRET=2; reset 1 cycle, then 5 cycles valid=11 with chained PCs from 0x60 step 4, then done_in → order_count 10, ch_order of the last cycle {9,8}, PASS, err_code 0.
- valid=01 pc_wdata 0x64, next cycle pc_rdata[0]=0x70 (PCCHK_EN) → FAIL next cycle, err_code 0x0001, err_order 1, order_count 1.
- valid=10 on a cycle with order_count 3 → FAIL, err_code 0x0003, err_order 3; same run without the macro gives the same result.
- No retire for WDT_LIMIT=8 cycles after one retire → FAIL on the 8th idle edge, err_code 0x0002. A retire on cycle 7 instead keeps state RUN.
- Same cycle: errcode_in=0x00AB, done_in=1, PC mismatch → FAIL, err_code 0x00AB. A later errcode_in=0x0001 leaves err_code 0x00AB.
- Reset asserted while in FAIL, and separately mid-run with order_count 7 → next cycle state IDLE, order_count 0, err_code 0; a first retire at any PC is accepted.

Source files
------------

// File: rtl/psp_retire_monitor.sv
// Retirement tracker: numbers retired instructions, checks mask/PC/watchdog rules, latches first error.
// Optional build macro PSP_RETIRE_PCCHK_EN enables PC continuity checking (error 0x0001).
module psp_retire_monitor #(
  parameter int NRET      = 2,
  parameter int XLEN      = 32,
  parameter int ORDER_W   = 64,
  parameter int WDT_W     = 16,
  parameter int WDT_LIMIT = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*XLEN-1:0]    rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]    rvfi_pc_wdata,
  input  logic                    done_in,
  input  logic [15:0]             errcode_in,
  output logic [NRET*ORDER_W-1:0] ch_order,
  output logic [ORDER_W-1:0]      order_count,
  output logic [1:0]              state,
  output logic                    pass,
  output logic                    fail,
  output logic [15:0]             err_code,
  output logic [ORDER_W-1:0]      err_order
);

  localparam int CNT_W = $clog2(NRET + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t             r_state;
  logic [ORDER_W-1:0] r_order_count;
  logic [ORDER_W-1:0] r_err_order;
  logic [15:0]        r_err_code;
  logic [WDT_W-1:0]   r_wdt;

  logic               w_active;
  logic               w_any;
  logic               w_mask_ok;
  logic               w_gap;
  logic [CNT_W-1:0]   w_retire_cnt;
  logic               w_pc_err;
  logic               w_wdt_hit;
  logic [15:0]        w_err_code;
  logic               w_err;

  assign w_active = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_any    = |rvfi_valid;

  // A legal mask has no valid bit above a cleared one.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    w_mask_ok    = 1'b1;
    w_gap        = 1'b0;
    w_retire_cnt = '0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        if (w_gap) w_mask_ok = 1'b0;
        w_retire_cnt = w_retire_cnt + CNT_W'(1);
      end else begin
        w_gap = 1'b1;
      end
    end
  end

  always_comb begin
    ch_order = '0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) ch_order[i*ORDER_W +: ORDER_W] = r_order_count + ORDER_W'(i);
    end
  end

`ifdef PSP_RETIRE_PCCHK_EN
  logic [XLEN-1:0] r_last_pc;
  logic            r_last_pc_valid;
  logic [XLEN-1:0] w_next_pc;

  always_comb begin
    w_pc_err  = 1'b0;
    w_next_pc = r_last_pc;
    if (rvfi_valid[0] && r_last_pc_valid && (rvfi_pc_rdata[XLEN-1:0] != r_last_pc))
      w_pc_err = 1'b1;
    for (int i = 1; i < NRET; i++) begin
      if (rvfi_valid[i] &&
          (rvfi_pc_rdata[i*XLEN +: XLEN] != rvfi_pc_wdata[(i-1)*XLEN +: XLEN]))
        w_pc_err = 1'b1;
    end
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) w_next_pc = rvfi_pc_wdata[i*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_pc       <= '0;
      r_last_pc_valid <= 1'b0;
    end else if (w_active && w_any && !w_err) begin
      r_last_pc       <= w_next_pc;
      r_last_pc_valid <= 1'b1;
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{rvfi_pc_rdata, rvfi_pc_wdata};
  assign w_pc_err    = 1'b0;
`endif

  assign w_wdt_hit = !w_any && (r_wdt == WDT_W'(WDT_LIMIT - 1));

  // External code outranks mask, then PC, then watchdog.
  always_comb begin
    w_err_code = 16'h0000;
    if (errcode_in != 16'h0000) w_err_code = errcode_in;
    else if (!w_mask_ok)        w_err_code = 16'h0003;
    else if (w_pc_err)          w_err_code = 16'h0001;
    else if (w_wdt_hit)         w_err_code = 16'h0002;
  end

  assign w_err = (w_err_code != 16'h0000);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state       <= S_IDLE;
      r_order_count <= '0;
      r_err_code    <= '0;
      r_err_order   <= '0;
      r_wdt         <= '0;
    end else if (w_active) begin
      if (w_err) begin
        r_state     <= S_FAIL;
        r_err_code  <= w_err_code;
        r_err_order <= r_order_count;
      end else begin
        r_order_count <= r_order_count + ORDER_W'(w_retire_cnt);
        r_wdt         <= w_any ? '0 : r_wdt + WDT_W'(1);
        if (done_in)    r_state <= S_PASS;
        else if (w_any) r_state <= S_RUN;
      end
    end
  end

  assign order_count = r_order_count;
  assign state       = r_state;
  assign pass        = (r_state == S_PASS);
  assign fail        = (r_state == S_FAIL);
  assign err_code    = r_err_code;
  assign err_order   = r_err_order;

endmodule

// File: tb/tb_psp_retire_monitor.sv
// Self-checking bench for psp_retire_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_psp_retire_monitor;

  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int OW   = 64;
  localparam int WDTL = 8;

`ifdef PSP_RETIRE_PCCHK_EN
  localparam bit PCCHK = 1'b1;
`else
  localparam bit PCCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NRET-1:0]   valid = '0;
  logic [NRET*XLEN-1:0] pr = '0;
  logic [NRET*XLEN-1:0] pw = '0;
  logic              done = 1'b0;
  logic [15:0]       errc = '0;

  logic [NRET*OW-1:0] ch_order;
  logic [OW-1:0]      order_count;
  logic [1:0]         state;
  logic               pass;
  logic               fail;
  logic [15:0]        err_code;
  logic [OW-1:0]      err_order;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int          m_state;
  logic [OW-1:0] m_count;
  logic [OW-1:0] m_err_order;
  logic [15:0] m_err_code;
  int          m_wdt;
  logic [31:0] m_last_pc;
  bit          m_last_valid;

  psp_retire_monitor #(
    .NRET(NRET), .XLEN(XLEN), .ORDER_W(OW), .WDT_W(16), .WDT_LIMIT(WDTL)
  ) dut (
    .clk(clk), .reset(reset), .rvfi_valid(valid), .rvfi_pc_rdata(pr),
    .rvfi_pc_wdata(pw), .done_in(done), .errcode_in(errc),
    .ch_order(ch_order), .order_count(order_count), .state(state),
    .pass(pass), .fail(fail), .err_code(err_code), .err_order(err_order)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic model_step();
    int n;
    int h;
    bit legal;
    bit pc_bad;
    bit wdt_hit;
    logic [15:0] code;
    if (reset) begin
      m_state = 0; m_count = '0; m_err_code = '0; m_err_order = '0;
      m_wdt = 0; m_last_pc = '0; m_last_valid = 1'b0;
      return;
    end
    if (m_state >= 2) return;
    n = $countones(valid);
    legal = (valid == NRET'((1 << n) - 1));
    pc_bad = 1'b0;
    if (PCCHK) begin
      if (valid[0] && m_last_valid && pr[31:0] != m_last_pc) pc_bad = 1'b1;
      if (valid[1] && pr[63:32] != pw[31:0]) pc_bad = 1'b1;
    end
    wdt_hit = (n == 0) && (m_wdt + 1 >= WDTL);
    if (errc != 0)   code = errc;
    else if (!legal) code = 16'h0003;
    else if (pc_bad) code = 16'h0001;
    else if (wdt_hit) code = 16'h0002;
    else             code = 16'h0000;
    if (code != 0) begin
      m_state = 3; m_err_code = code; m_err_order = m_count;
    end else begin
      m_count = m_count + OW'(n);
      m_wdt = (n == 0) ? m_wdt + 1 : 0;
      if (n > 0) begin
        h = valid[1] ? 1 : 0;
        m_last_pc = pw[h*32 +: 32];
        m_last_valid = 1'b1;
      end
      if (done) m_state = 2;
      else if (n > 0) m_state = 1;
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic [31:0] r0, input logic [31:0] w0,
                       input logic [31:0] r1, input logic [31:0] w1,
                       input logic d, input logic [15:0] e);
    valid = v; pr = {r1, r0}; pw = {w1, w0}; done = d; errc = e;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(2'b11, 32'h123, 32'h456, 32'h789, 32'habc, 1'b1, 16'h0055);
    tick();
    reset = 1'b0;
    apply(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset.state got %0d want 0", state); end
    vectors++; if (order_count !== 64'd0) begin miscompares++; $display("FAIL reset.order got %0d want 0", order_count); end
    vectors++; if (err_code !== 16'd0 || err_order !== 64'd0) begin miscompares++; $display("FAIL reset.err got %h/%0d want 0/0", err_code, err_order); end
    vectors++; if (pass !== 1'b0 || fail !== 1'b0) begin miscompares++; $display("FAIL reset.flags got %b%b want 00", pass, fail); end
    vectors++; if (ch_order !== '0) begin miscompares++; $display("FAIL reset.ch_order got %h want 0", ch_order); end
  endtask

  task automatic test_pass_run();
    logic [31:0] p;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      p = 32'h60 + 32'(8 * k);
      apply(2'b11, p, p + 4, p + 4, p + 8, 1'b0, 16'h0);
      if (k == 4) begin
        vectors++; if (ch_order !== {64'd9, 64'd8}) begin miscompares++; $display("FAIL pass_run.ch_order got %h want {9,8}", ch_order); end
      end
      tick();
    end
    apply(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 16'h0);
    tick();
    vectors++; if (order_count !== 64'd10) begin miscompares++; $display("FAIL pass_run.order got %0d want 10", order_count); end
    vectors++; if (state !== 2'd2 || pass !== 1'b1 || fail !== 1'b0) begin miscompares++; $display("FAIL pass_run.state got %0d p%b f%b want 2 p1 f0", state, pass, fail); end
    vectors++; if (err_code !== 16'd0) begin miscompares++; $display("FAIL pass_run.err got %h want 0", err_code); end
    // PASS is absorbing: an error input now must be ignored
    apply(2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 16'h00ff);
    tick();
    vectors++; if (state !== 2'd2 || order_count !== 64'd10 || err_code !== 16'd0) begin miscompares++; $display("FAIL pass_run.absorb got st%0d ord%0d err%h want st2 ord10 err0", state, order_count, err_code); end
  endtask

  task automatic test_pc_mismatch();
    do_reset();
    apply(2'b01, 32'h60, 32'h64, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    apply(2'b01, 32'h70, 32'h74, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
`ifdef PSP_RETIRE_PCCHK_EN
    vectors++; if (state !== 2'd3 || fail !== 1'b1) begin miscompares++; $display("FAIL pc_mismatch.state got %0d want 3", state); end
    vectors++; if (err_code !== 16'h0001 || err_order !== 64'd1) begin miscompares++; $display("FAIL pc_mismatch.err got %h/%0d want 0001/1", err_code, err_order); end
    vectors++; if (order_count !== 64'd1) begin miscompares++; $display("FAIL pc_mismatch.order got %0d want 1", order_count); end
`else
    vectors++; if (state !== 2'd1 || fail !== 1'b0) begin miscompares++; $display("FAIL pc_mismatch.state got %0d want 1", state); end
    vectors++; if (err_code !== 16'h0000 || order_count !== 64'd2) begin miscompares++; $display("FAIL pc_mismatch.order got err%h ord%0d want err0 ord2", err_code, order_count); end
`endif
  endtask

  task automatic test_mask_illegal();
    do_reset();
    apply(2'b11, 32'h60, 32'h64, 32'h64, 32'h68, 1'b0, 16'h0);
    tick();
    apply(2'b01, 32'h68, 32'h6c, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    vectors++; if (order_count !== 64'd3) begin miscompares++; $display("FAIL mask.pre_order got %0d want 3", order_count); end
    apply(2'b10, 32'h6c, 32'h70, 32'h70, 32'h74, 1'b0, 16'h0);
    vectors++; if (ch_order !== {64'd4, 64'd0}) begin miscompares++; $display("FAIL mask.ch_order got %h want {4,0}", ch_order); end
    tick();
    vectors++; if (state !== 2'd3 || err_code !== 16'h0003) begin miscompares++; $display("FAIL mask.err got st%0d %h want st3 0003", state, err_code); end
    vectors++; if (err_order !== 64'd3 || order_count !== 64'd3) begin miscompares++; $display("FAIL mask.order got %0d/%0d want 3/3", err_order, order_count); end
    // Mask error outranks a simultaneous PC mismatch
    do_reset();
    apply(2'b01, 32'h60, 32'h64, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    apply(2'b10, 32'h200, 32'h204, 32'h300, 32'h304, 1'b0, 16'h0);
    tick();
    vectors++; if (err_code !== 16'h0003) begin miscompares++; $display("FAIL mask.prio got %h want 0003", err_code); end
  endtask

  task automatic test_watchdog();
    do_reset();
    apply(2'b01, 32'h60, 32'h64, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    apply(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
    for (int k = 0; k < WDTL - 1; k++) tick();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL wdt.before got %0d want 1", state); end
    tick();
    vectors++; if (state !== 2'd3 || err_code !== 16'h0002 || err_order !== 64'd1) begin miscompares++; $display("FAIL wdt.fire got st%0d %h/%0d want st3 0002/1", state, err_code, err_order); end
    do_reset();
    apply(2'b01, 32'h60, 32'h64, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    apply(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
    for (int k = 0; k < WDTL - 2; k++) tick();
    apply(2'b01, 32'h64, 32'h68, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    apply(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
    for (int k = 0; k < WDTL - 1; k++) tick();
    vectors++; if (state !== 2'd1 || order_count !== 64'd2) begin miscompares++; $display("FAIL wdt.cleared got st%0d ord%0d want st1 ord2", state, order_count); end
  endtask

  task automatic test_error_priority();
    do_reset();
    apply(2'b01, 32'h60, 32'h64, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    apply(2'b01, 32'h100, 32'h104, 32'h0, 32'h0, 1'b1, 16'h00ab);
    tick();
    vectors++; if (state !== 2'd3 || pass !== 1'b0 || err_code !== 16'h00ab) begin miscompares++; $display("FAIL prio.ext got st%0d p%b %h want st3 p0 00ab", state, pass, err_code); end
    vectors++; if (err_order !== 64'd1 || order_count !== 64'd1) begin miscompares++; $display("FAIL prio.order got %0d/%0d want 1/1", err_order, order_count); end
    apply(2'b01, 32'h104, 32'h108, 32'h0, 32'h0, 1'b0, 16'h0001);
    tick();
    vectors++; if (err_code !== 16'h00ab || order_count !== 64'd1) begin miscompares++; $display("FAIL prio.first_wins got %h ord%0d want 00ab ord1", err_code, order_count); end
  endtask

  task automatic test_reset_recovery();
    do_reset();
    vectors++; if (state !== 2'd0 || order_count !== 64'd0 || err_code !== 16'd0 || err_order !== 64'd0) begin miscompares++; $display("FAIL rst_fail got st%0d ord%0d err%h want 0/0/0", state, order_count, err_code); end
    for (int k = 0; k < 3; k++) begin
      apply(2'b11, 32'h400 + 32'(8*k), 32'h404 + 32'(8*k), 32'h404 + 32'(8*k), 32'h408 + 32'(8*k), 1'b0, 16'h0);
      tick();
    end
    apply(2'b01, 32'h418, 32'h41c, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    vectors++; if (order_count !== 64'd7) begin miscompares++; $display("FAIL rst_mid.pre got %0d want 7", order_count); end
    do_reset();
    vectors++; if (state !== 2'd0 || order_count !== 64'd0 || err_code !== 16'd0) begin miscompares++; $display("FAIL rst_mid got st%0d ord%0d err%h want 0/0/0", state, order_count, err_code); end
    apply(2'b01, 32'h1000, 32'h1004, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    vectors++; if (state !== 2'd1 || order_count !== 64'd1 || fail !== 1'b0) begin miscompares++; $display("FAIL rst_first got st%0d ord%0d f%b want 1/1/0", state, order_count, fail); end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] v;
    logic [31:0] base, w0, r1;
    logic [NRET*OW-1:0] exp_ch;
    for (int c = 0; c < 600; c++) begin
      reset = ((m_state >= 2) && ($urandom_range(3) == 0)) || ($urandom_range(99) == 0);
      r = $urandom_range(19);
      v = (r < 3) ? 2'b00 : (r < 8) ? 2'b01 : (r < 18) ? 2'b11 : 2'b10;
      base = m_last_valid ? m_last_pc : ($urandom & 32'hffff_fffc);
      if ($urandom_range(24) == 0) base = base ^ 32'h4;
      w0 = ($urandom_range(3) == 0) ? ($urandom & 32'hffff_fffc) : base + 4;
      r1 = ($urandom_range(24) == 0) ? w0 + 8 : w0;
      apply(v, base, w0, r1, r1 + 4, ($urandom_range(29) == 0),
            ($urandom_range(59) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0);
      exp_ch = '0;
      if (v[0]) exp_ch[OW-1:0] = m_count;
      if (v[1]) exp_ch[2*OW-1:OW] = m_count + 1;
      vectors++; if (ch_order !== exp_ch) begin miscompares++; $display("FAIL rand.ch_order[%0d] got %h want %h", c, ch_order, exp_ch); end
      tick();
      vectors++; if (state !== 2'(m_state) || pass !== (m_state == 2) || fail !== (m_state == 3)) begin miscompares++; $display("FAIL rand.state[%0d] got %0d p%b f%b want %0d", c, state, pass, fail, m_state); end
      vectors++; if (order_count !== m_count) begin miscompares++; $display("FAIL rand.order[%0d] got %0d want %0d", c, order_count, m_count); end
      vectors++; if (err_code !== m_err_code || err_order !== m_err_order) begin miscompares++; $display("FAIL rand.err[%0d] got %h/%0d want %h/%0d", c, err_code, err_order, m_err_code, m_err_order); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_pc_mismatch();
    test_mask_illegal();
    test_watchdog();
    test_error_priority();
    test_reset_recovery();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
